// File: rtl/serdes_pkg.sv
// rtl/serdes_pkg.sv - shared serial frame constants, RX state encoding, parity helper
package serdes_pkg;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_W    = 8;

  typedef enum logic [2:0] {
    ST_WAIT_HIGH,
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_par(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/serdes_rx_if.sv
// rtl/serdes_rx_if.sv - serial line in, received byte and status out
interface serdes_rx_if;
  import serdes_pkg::*;

  logic              Sin;
  logic [DATA_W-1:0] Pout;
  logic              valid;
  logic              err;
  logic              busy;

  modport master (output Sin, input Pout, input valid, input err, input busy);
  modport slave  (input Sin, output Pout, output valid, output err, output busy);

endinterface

// File: rtl/serdes_sync2.sv
// rtl/serdes_sync2.sv - two-flop synchronizer that resets to the idle-high line level
module serdes_sync2 (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_meta <= 1'b1;
      r_q    <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/serdes_rx.sv
// rtl/serdes_rx.sv - oversampled UART-style frame receiver with parity and framing checks
module serdes_rx
  import serdes_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_EN    = 1'b1
) (
  input  logic        CLOCK_50,
  input  logic        resetN,
  serdes_rx_if.slave  bus
);

  localparam int H     = CLKS_PER_BIT / 2;
  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(H - 1);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_W - 1);

  rx_state_t         r_state, w_state;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic [2:0]        r_idx, w_idx;
  logic [DATA_W-1:0] r_shift, w_shift;
  logic              r_perr, w_perr;
  logic [DATA_W-1:0] r_pout, w_pout;
  logic              r_valid, w_valid;
  logic              r_err, w_err;
  logic              w_s;
  logic              w_cnt_done;

  serdes_sync2 u_sync (
    .i_clk    (CLOCK_50),
    .i_resetn (resetN),
    .i_d      (bus.Sin),
    .o_q      (w_s)
  );

  assign w_cnt_done = (r_cnt == CNT_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (!resetN) begin
      r_state <= ST_WAIT_HIGH;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_perr  <= 1'b0;
      r_pout  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_shift <= w_shift;
      r_perr  <= w_perr;
      r_pout  <= w_pout;
      r_valid <= w_valid;
      r_err   <= w_err;
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_idx   = r_idx;
    w_shift = r_shift;
    w_perr  = r_perr;
    w_pout  = r_pout;
    w_valid = 1'b0;
    w_err   = r_err;

    case (r_state)
      // A line held low (break) must return high before a new start is accepted.
      ST_WAIT_HIGH: begin
        if (w_s) w_state = ST_IDLE;
      end

      ST_IDLE: begin
        if (w_s == START_BIT) begin
          w_cnt   = '0;
          w_state = ST_START;
        end
      end

      ST_START: begin
        if (r_cnt == CNT_HALF) begin
          if (w_s != START_BIT) begin
            w_state = ST_IDLE;
          end else begin
            w_cnt   = '0;
            w_idx   = '0;
            w_perr  = 1'b0;
            w_state = ST_DATA;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      ST_DATA: begin
        if (w_cnt_done) begin
          w_shift[r_idx] = w_s;
          w_cnt          = '0;
          if (r_idx == IDX_LAST) w_state = PARITY_EN ? ST_PARITY : ST_STOP;
          else                   w_idx   = r_idx + 1'b1;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      ST_PARITY: begin
        if (w_cnt_done) begin
          w_perr  = w_s ^ even_par(r_shift);
          w_cnt   = '0;
          w_state = ST_STOP;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      // Leaving to IDLE mid-stop-bit lets a back-to-back start edge be caught.
      ST_STOP: begin
        if (w_cnt_done) begin
          w_cnt = '0;
          if (w_s != STOP_BIT) begin
            w_err   = 1'b1;
            w_state = ST_WAIT_HIGH;
          end else if (r_perr) begin
            w_err   = 1'b1;
            w_state = ST_IDLE;
          end else begin
            w_pout  = r_shift;
            w_valid = 1'b1;
            w_err   = 1'b0;
            w_state = ST_IDLE;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      default: w_state = ST_WAIT_HIGH;
    endcase
  end

  assign bus.Pout  = r_pout;
  assign bus.valid = r_valid;
  assign bus.err   = r_err;
  assign bus.busy  = !((r_state == ST_WAIT_HIGH) || (r_state == ST_IDLE));

endmodule

// File: tb/tb_serdes_rx.sv
// tb/tb_serdes_rx.sv - directed frame vectors against serdes_rx with hand-computed results
module tb_serdes_rx;
  import serdes_pkg::*;

  localparam int C = 4;
  localparam int H = 2;
  localparam int N = 10;
  localparam int LAT = 3 + H + N * C;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   fall_cyc = 0;
  int   last_valid_cyc = 0;
  logic busy_seen = 1'b0;
  logic [7:0] hist[$];

  always #5 clk = ~clk;

  serdes_rx_if bus ();

  serdes_rx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1)) dut (
    .CLOCK_50 (clk),
    .resetN   (resetN),
    .bus      (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (bus.valid === 1'b1) begin
      hist.push_back(bus.Pout);
      last_valid_cyc = cyc;
    end
    if (bus.busy === 1'b1) busy_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    bus.Sin = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive(1'b1, n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stopv);
    fall_cyc = cyc;
    drive(1'b0, C);
    for (int i = 0; i < 8; i++) drive(d[i], C);
    drive(even_par(d) ^ pflip, C);
    drive(stopv, C);
  endtask

  initial begin
    logic bh;
    int   nv;
    bus.Sin = 1'b1;
    resetN  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pout", bus.Pout, 8'h00);
    chk("rst_valid", bus.valid, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    resetN = 1'b1;
    idle(10);

    busy_seen = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(8);
    chk("a5_count", hist.size(), 1);
    chk("a5_pout", bus.Pout, 8'hA5);
    chk("a5_err", bus.err, 1'b0);
    chk("a5_busy_seen", busy_seen, 1'b1);
    chk("a5_busy_end", bus.busy, 1'b0);
    chk("a5_latency", last_valid_cyc - fall_cyc, LAT);

    send_frame(8'h3C, 1'b1, 1'b1);
    idle(8);
    chk("par_count", hist.size(), 1);
    chk("par_pout", bus.Pout, 8'hA5);
    chk("par_err", bus.err, 1'b1);
    send_frame(8'h01, 1'b0, 1'b1);
    idle(8);
    chk("01_count", hist.size(), 2);
    chk("01_pout", bus.Pout, 8'h01);
    chk("01_err", bus.err, 1'b0);

    send_frame(8'h55, 1'b0, 1'b0);
    bh = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bus.Sin = 1'b0;
      @(negedge clk);
      if (i >= 4) bh = bh | bus.busy;
    end
    chk("brk_busy_low", bh, 1'b0);
    chk("brk_err", bus.err, 1'b1);
    chk("brk_count", hist.size(), 2);
    idle(8);
    send_frame(8'h80, 1'b0, 1'b1);
    idle(8);
    chk("80_count", hist.size(), 3);
    chk("80_pout", bus.Pout, 8'h80);
    chk("80_err", bus.err, 1'b0);

    busy_seen = 1'b0;
    drive(1'b0, 1);
    idle(12);
    chk("gl_busy_seen", busy_seen, 1'b1);
    chk("gl_busy", bus.busy, 1'b0);
    chk("gl_count", hist.size(), 3);
    chk("gl_err", bus.err, 1'b0);

    send_frame(8'hFF, 1'b0, 1'b1);
    send_frame(8'h00, 1'b0, 1'b1);
    idle(10);
    chk("b2b_count", hist.size(), 5);
    chk("b2b_first", hist[3], 8'hFF);
    chk("b2b_second", hist[4], 8'h00);
    chk("b2b_err", bus.err, 1'b0);

    send_frame(8'h5A, 1'b0, 1'b1);
    idle(6);
    send_frame(8'h77, 1'b1, 1'b1);
    idle(6);
    chk("pre_rst_pout", bus.Pout, 8'h5A);
    chk("pre_rst_err", bus.err, 1'b1);

    hist.delete();
    fork
      begin
        repeat (4) send_frame(8'h00, 1'b0, 1'b1);
      end
      begin
        repeat (15) @(negedge clk);
        resetN = 1'b0;
        @(negedge clk);
        chk("mid_rst_pout", bus.Pout, 8'h00);
        chk("mid_rst_valid", bus.valid, 1'b0);
        chk("mid_rst_err", bus.err, 1'b0);
        chk("mid_rst_busy", bus.busy, 1'b0);
        resetN = 1'b1;
      end
    join
    idle(10);
    nv = hist.size();
    chk("lb_have_valid", (nv >= 1) ? 1 : 0, 1);
    chk("lb_first", (nv >= 1) ? {24'h0, hist[0]} : 32'h1FF, 8'h00);
    chk("lb_err", bus.err, 1'b0);
    chk("lb_busy", bus.busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/serdes_rx.md
Name: serdes_rx

Overview:
- Serial-to-parallel receiver that sits directly downstream of the TX serializer. Its Sin input takes the TX Sout line.
- Recovers 11-bit frames, all on the shared CLOCK_50 domain:
  - 1 start bit (0)
  - 8 data bits, LSB first
  - 1 even-parity bit
  - 1 stop bit (1)
- Presents each good byte on Pout with a one-cycle valid strobe. Flags parity and framing faults on err.

Parameters:
- CLKS_PER_BIT, 4: clock cycles per serial bit. Must be even and ≥2; H = CLKS_PER_BIT/2.
- PARITY_EN, 1: 1 = parity bit present and checked; 0 = 10-bit frame with no parity slot.

Ports:
- CLOCK_50  input  1  system clock; all logic on the rising edge.
- resetN  input  1  synchronous, active-low reset.
- Sin  input  1  serial line from TX Sout. Idle level is high.
- Pout  output  8  last correctly received byte.
- valid  output  1  one-cycle pulse; Pout was just updated.
- err  output  1  sticky error flag.
- busy  output  1  high while a frame is in progress (any state other than IDLE/WAIT_HIGH).

Behaviour:
- Reset: sampled on a CLOCK_50 edge with resetN=0.
  - Outputs: Pout=8'h00, valid=0, err=0, busy=0.
  - Internal: state=WAIT_HIGH, counters=0, synchronizer flops=1.
  - Reset mid-frame abandons the frame immediately; no valid, no err.
- Input path: Sin passes through a 2-flop synchronizer (s). All decisions use s, so there is 2 cycles of input latency.
- Bit counter cnt runs 0..CLKS_PER_BIT-1. Bit index idx runs 0..7.
- States:
  - WAIT_HIGH: stay until s=1, then go to IDLE. Blocks re-triggering on a held-low or break line.
  - IDLE: if s=0, set cnt=0 and go to START.
  - START: count to cnt=H-1, then check s (mid-bit).
    - s=1: false start; return to IDLE with no err.
    - s=0: set cnt=0, idx=0, go to DATA.
  - DATA: at cnt=CLKS_PER_BIT-1, sample s into shift[idx] (LSB first) and set cnt=0.
    - If idx=7: go to PARITY if PARITY_EN, otherwise go to STOP.
    - Otherwise: idx+1.
    - Every sample therefore lands at bit centre.
  - PARITY: at cnt=CLKS_PER_BIT-1, store perr = s XOR (^shift), then go to STOP.
  - STOP: at cnt=CLKS_PER_BIT-1, sample s.
    - Good frame (s=1 and perr=0): next cycle Pout=shift, valid=1, err=0. Go to IDLE.
    - s=0 (framing error): valid stays 0, Pout is unchanged, err=1. Go to WAIT_HIGH.
    - s=1 with perr=1 (parity error): valid stays 0, Pout is unchanged, err=1. Go to IDLE.
- valid is high for exactly one cycle per good frame.
- err stays set until the next good frame or reset.
- Latency: let cycle 0 be the edge where s is first seen low in IDLE. The stop sample is at cycle H + N*CLKS_PER_BIT, where N = 10 with parity or 9 without. valid/Pout update on the following edge.
- Back-to-back frames:
  - After a good stop sample the FSM is in IDLE with about H cycles of stop bit remaining.
  - The next start edge is accepted with zero idle gap beyond the stop bit.
- Simultaneous events: resetN=0 overrides every state and output update in that cycle.

Decomposition:
- Shared package serdes_pkg:
  - Frame constants: START_BIT=0, STOP_BIT=1, DATA_W=8.
  - State encoding: WAIT_HIGH, IDLE, START, DATA, PARITY, STOP.
  - Parity function even_par(byte), to be shared with TX.
- One natural sub-module: serdes_sync2, the 2-flop synchronizer with reset value 1.
- Counters and FSM stay in serdes_rx.

Test Plan:
- Good frame, CLKS_PER_BIT=4: reset, Sin idle high, drive 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, parity 0, stop 1) → valid pulses once, Pout=8'hA5, err=0, busy drops after stop; valid edge exactly at the latency formula.
- Parity error: drive 0x3C with parity bit 1 (correct is 0) → no valid, Pout keeps previous 8'hA5, err=1. Then a good 0x01 (parity 1) → Pout=8'h01, valid pulse, err=0.
- Framing/break: drive 0x55 with stop=0, then hold Sin low for 40 cycles, then high → err=1, no valid, busy=0 while low with no re-trigger. A following good 0x80 is received correctly.
- Glitch: Sin low for 1 bit-period/4 (1 cycle) then high → returns to IDLE, no valid, err unchanged.
- Back-to-back: 0xFF then 0x00 with no idle gap → two valid pulses, Pout=8'hFF then 8'h00, err=0.
- Loopback/reset: TX→serdes_rx with Pin=8'h00 and send held high, then assert resetN=0 mid-frame for 1 cycle → all outputs reset; after release, the first complete frame decodes to 8'h00 with valid and no err.
